// File: rtl/counter_timer_chain.sv
// Programmable up/down counter/timer with chain strobe/stop, terminal-count irq and register bus.
// Optional CAPTURE register and synchroniser enabled by defining COUNTER_TIMER_CAPTURE_EN.
module counter_timer_chain #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  reg_addr,
  input  logic        reg_we,
  input  logic        reg_re,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_ack,
  input  logic        enable_in,
  input  logic        stop_in,
  output logic        strobe_out,
  output logic        stop_out,
  output logic        irq,
  input  logic        capture_in
);

  localparam int unsigned CFG_W = 5;
  localparam int unsigned BUS_W = 32;

  localparam logic [1:0] ADDR_CONFIG  = 2'd0;
  localparam logic [1:0] ADDR_VALUE   = 2'd1;
  localparam logic [1:0] ADDR_DATA    = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;

  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] data;
  logic [CFG_W-1:0] cfg;
  logic [WIDTH-1:0] value_nxt;
  logic [BUS_W-1:0] rd_mux;
  logic [WIDTH-1:0] capture_val;

  logic cfg_en, cfg_oneshot, cfg_up, cfg_chain, cfg_irq_ena;
  logic wr_cfg, wr_value, wr_data;
  logic qual, at_term, term;

  assign cfg_en      = cfg[0];
  assign cfg_oneshot = cfg[1];
  assign cfg_up      = cfg[2];
  assign cfg_chain   = cfg[3];
  assign cfg_irq_ena = cfg[4];

  // Count qualification, terminal detection and next count value
  always_comb begin
    wr_cfg    = reg_we && (reg_addr == ADDR_CONFIG);
    wr_value  = reg_we && (reg_addr == ADDR_VALUE);
    wr_data   = reg_we && (reg_addr == ADDR_DATA);
    qual      = cfg_en & ~stop_in & (cfg_chain ? enable_in : 1'b1) & ~stop_out;
    at_term   = cfg_up ? (value == data) : (value == '0);
    term      = qual & at_term & ~wr_value;
    value_nxt = value;
    if (qual) begin
      if (!at_term)
        value_nxt = cfg_up ? value + WIDTH'(1) : value - WIDTH'(1);
      else if (!cfg_oneshot)
        value_nxt = cfg_up ? '0 : data;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_CONFIG:  rd_mux = BUS_W'(cfg);
      ADDR_VALUE:   rd_mux = BUS_W'(value);
      ADDR_DATA:    rd_mux = BUS_W'(data);
      ADDR_CAPTURE: rd_mux = BUS_W'(capture_val);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value      <= '0;
      data       <= '0;
      cfg        <= '0;
      reg_rdata  <= '0;
      reg_ack    <= 1'b0;
      strobe_out <= 1'b0;
      stop_out   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      value <= wr_value ? reg_wdata[WIDTH-1:0] : value_nxt;
      if (wr_data)
        data <= reg_wdata[WIDTH-1:0];
      if (wr_cfg)
        cfg <= reg_wdata[CFG_W-1:0];
      strobe_out <= term;
      irq        <= term & cfg_irq_ena;
      // Any register write releases a held oneshot
      if (wr_cfg || wr_value || wr_data)
        stop_out <= 1'b0;
      else if (term && cfg_oneshot)
        stop_out <= 1'b1;
      reg_ack <= reg_we | reg_re;
      if (reg_re)
        reg_rdata <= rd_mux;
    end
  end

`ifdef COUNTER_TIMER_CAPTURE_EN
  logic [2:0] cap_sync;

  // Two-flop synchroniser plus edge history; latches the pre-count value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_sync    <= '0;
      capture_val <= '0;
    end else begin
      cap_sync <= {cap_sync[1:0], capture_in};
      if (cap_sync[1] && !cap_sync[2])
        capture_val <= value;
    end
  end
`else
  logic unused_capture_in;
  assign unused_capture_in = capture_in;
  assign capture_val       = '0;
`endif

endmodule
